// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file dump reader: FSM states, sizes, beat layout.
// Build option: REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum beat to each dump.
// Widths here are the reader's defaults; the top must be built with matching widths.
package regfile_dump_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_REGS       = 2 ** ADDR_WIDTH_DEF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HALT = 3'd1,
    ST_STREAM    = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

  // One output beat: register index, value, end-of-dump and checksum markers.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] idx;
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      last;
    logic                      csum;
  } beat_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Halts the core, walks every register-file entry and streams (index, data) beats out.
// Latency: first beat one cycle after STREAM is entered, then 1 beat/cycle if the sink is ready.
// Backpressure: a beat is held stable while dump_ready_i=0; dropping halt_ack_i mid-dump aborts.
// Build option REGFILE_DUMP_CHECKSUM_EN adds a trailing XOR-checksum beat (dump_csum_o=1).
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  abort_o,
  output logic                  halt_req_o,
  input  logic                  halt_ack_i,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic [ADDR_WIDTH-1:0] dump_idx_o,
  output logic [DATA_WIDTH-1:0] dump_data_o,
  output logic                  dump_last_o,
  output logic                  dump_csum_o
);

  localparam int                    NREGS    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NREGS - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q;
  beat_t                   beat_q;
  logic                    valid_q;
  logic                    halt_req_q;
  logic                    done_q;
  logic                    abort_q;
  logic                    out_free;
  logic [DATA_WIDTH-1:0]   csum_val;

  // The holding register may take a new beat when empty or being drained this cycle.
  assign out_free = !valid_q || dump_ready_i;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  logic [DATA_WIDTH-1:0] acc_q;

  // The checksum beat is loaded in the same cycle the final register beat is accepted,
  // so fold that beat's data in here rather than waiting for the accumulator.
  assign csum_val = acc_q ^ beat_q.data;

  // Accumulate the data of every accepted register beat; cleared as each dump begins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q <= '0;
    end else if (state_q == ST_WAIT_HALT && halt_ack_i) begin
      acc_q <= '0;
    end else if ((state_q == ST_STREAM || state_q == ST_DRAIN) && halt_ack_i &&
                 valid_q && dump_ready_i && !beat_q.csum) begin
      acc_q <= acc_q ^ beat_q.data;
    end
  end
`else
  localparam bit CSUM_EN = 1'b0;
  assign csum_val = '0;
`endif

  // Dump sequencer with all outputs registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      valid_q    <= 1'b0;
      halt_req_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            halt_req_q <= 1'b1;
            state_q    <= ST_WAIT_HALT;
          end
        end
        ST_WAIT_HALT: begin
          if (halt_ack_i) begin
            rd_ptr_q <= '0;
            state_q  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (!halt_ack_i) begin
            valid_q    <= 1'b0;
            halt_req_q <= 1'b0;
            abort_q    <= 1'b1;
            beat_q     <= '0;
            state_q    <= ST_IDLE;
          end else if (out_free) begin
            valid_q     <= 1'b1;
            beat_q.idx  <= rd_ptr_q;
            beat_q.data <= (rd_ptr_q == '0) ? '0 : rf_data_i;
            beat_q.last <= (rd_ptr_q == LAST_IDX) && !CSUM_EN;
            beat_q.csum <= 1'b0;
            // Pointer parks on the last index instead of wrapping.
            if (rd_ptr_q == LAST_IDX) begin
              state_q <= ST_DRAIN;
            end else begin
              rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!halt_ack_i) begin
            valid_q    <= 1'b0;
            halt_req_q <= 1'b0;
            abort_q    <= 1'b1;
            beat_q     <= '0;
            state_q    <= ST_IDLE;
          end else if (dump_ready_i) begin
            if (CSUM_EN && !beat_q.csum) begin
              beat_q.idx  <= '0;
              beat_q.data <= csum_val;
              beat_q.last <= 1'b1;
              beat_q.csum <= 1'b1;
            end else begin
              valid_q    <= 1'b0;
              halt_req_q <= 1'b0;
              done_q     <= 1'b1;
              beat_q     <= '0;
              state_q    <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign abort_o      = abort_q;
  assign halt_req_o   = halt_req_q;
  assign rf_addr_o    = rd_ptr_q;
  assign dump_valid_o = valid_q;
  assign dump_idx_o   = beat_q.idx;
  assign dump_data_o  = beat_q.data;
  assign dump_last_o  = beat_q.last;
  assign dump_csum_o  = beat_q.csum;

endmodule
